wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Single-port writeback arbiter placed between the execution pipelines (ALU, memory, M1–M5 multiply) and the ROB result-write/bypass port. Each source presents at most one result per cycle. The block grants one result per cycle using round-robin priority and registers the winner onto the writeback bus. A losing result is parked in a 1-entry per-source hold buffer, and that source is stalled until the parked result drains.

## Interface
Parameters:
- WORD_SIZE, `WORD_SIZE: width of result and pc.
- INSTR_TYPE_SZ, `INSTR_TYPE_SZ: width of instruction type.
- ROB_ID_SZ, 7: ROB tag width.
- NUM_SRC, 3: number of requesting pipelines (0=ALU, 1=MEM, 2=MUL).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline squash (mispredict/exception).
- src_valid  in  NUM_SRC  per-source result present this cycle.
- src_instr_type  in  NUM_SRC*INSTR_TYPE_SZ  flattened; source i at [i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ].
- src_pc  in  NUM_SRC*WORD_SIZE  flattened, same packing.
- src_result  in  NUM_SRC*WORD_SIZE  flattened, same packing.
- src_rob_id  in  NUM_SRC*ROB_ID_SZ  flattened, same packing.
- src_stall  out  NUM_SRC  per-source freeze request; equals that source's hold-buffer valid bit.
- wb_valid  out  1  registered writeback valid.
- wb_instr_type  out  INSTR_TYPE_SZ  registered.
- wb_pc  out  WORD_SIZE  registered.
- wb_result  out  WORD_SIZE  registered.
- wb_rob_id  out  ROB_ID_SZ  registered.
- wb_src  out  2  registered index of the granted source.

## Operation
- Per source i:
  - hold_valid_i is the hold-buffer valid bit, with hold data alongside.
  - req_i = hold_valid_i | src_valid_i.
  - Candidate data is the hold data if hold_valid_i, else the live inputs.
  - src_stall_i = hold_valid_i. This is a registered value with no combinational path from src_valid.
- A source must not change its inputs while src_stall_i is high. src_valid is ignored while stalled.
- Arbitration: round-robin over req. The search starts at rr_ptr and wraps modulo NUM_SRC. At most one grant per cycle.
- On grant to i:
  - Next edge: wb_* ← candidate_i, wb_valid←1, wb_src←i.
  - rr_ptr ← (i+1) mod NUM_SRC.
  - If hold_valid_i, it clears.
- No grant: wb_valid←0, wb data registers and rr_ptr hold their values.
- Ungranted source with src_valid_i & !hold_valid_i: hold ← live inputs, hold_valid_i←1.
- Ungranted source with hold_valid_i: hold is retained unchanged.
- The ROB always accepts writeback; there is no backpressure on wb_*.
- flush (edge), with reset taking priority over flush:
  - All hold_valid clear, wb_valid←0.
  - No grant is registered, and that cycle's src inputs are discarded.
  - rr_ptr is unchanged.
- reset (edge): every output and register goes to 0. This covers wb_valid, wb_instr_type, wb_pc, wb_result, wb_rob_id, wb_src, src_stall/hold_valid, hold data and rr_ptr.

## Timing
- Uncontended latency is 1 cycle: src_valid at cycle N gives wb_valid at N+1.
- A parked result is delivered at the earliest in cycle N+2. Worst case with NUM_SRC=3 and all sources continuously requesting is N+3, because round-robin bounds wait to NUM_SRC-1 grants.
- src_stall rises at the edge that parks a result. It falls at the edge that grants the parked result, so the source can present a new result in the following cycle.
- Simultaneous events:
  - A granted source whose hold was valid does not also capture a new input that cycle, because it is stalled.
  - reset dominates flush, and flush dominates grant.
- Sustained throughput is 1 writeback/cycle whenever any req is high.

## Structure
- Shared package wb_pkg holds:
  - ROB_ID_SZ, NUM_SRC and source indices SRC_ALU=0, SRC_MEM=1, SRC_MUL=2.
  - A struct wb_entry_t {instr_type, pc, result, rob_id} used for hold buffers and the output register.
- Sub-module rr_arbiter (NUM_SRC-parameterised):
  - Inputs req and rr_ptr; outputs a one-hot grant plus a binary index.
  - Purely combinational. rr_ptr is stored in wb_arbiter.

## Test plan
- Single ALU result: src_valid=3'b001, rob_id=5, result=0xDEAD_BEEF at cycle 1 → wb_valid=1, wb_rob_id=5, wb_result=0xDEADBEEF, wb_src=0 at cycle 2; src_stall stays 0.
- All three sources valid in the same cycle with rr_ptr=0 and rob_ids 10/11/12 → writebacks in consecutive cycles with rob_id 10, 11, 12. src_stall=3'b110 after the first edge, 3'b100 after the second, 3'b000 after the third.
- Round-robin fairness: ALU and MUL assert valid continuously for 6 cycles → wb_src alternates 0,2,0,2,… with no source starved for more than 1 cycle.
- Flush while MEM and MUL are parked → next cycle wb_valid=0 and src_stall=000; a later new ALU result writes back normally with the rr_ptr preserved.
- Reset asserted mid-stream, with holds full and wb_valid=1 → after the edge all outputs are 0. Inputs presented during reset produce no writeback.
- Stalled source toggling src_valid/data while src_stall=1 → the parked original data (e.g. rob_id 33) is the value written back, and the toggled values are ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, source indices and writeback entry type
package wb_pkg;
  localparam int WORD_SIZE = 32;
  localparam int INSTR_TYPE_SZ = 4;
  localparam int ROB_ID_SZ = 7;
  localparam int NUM_SRC = 3;
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_MUL = 2;
  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0] instr_type;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] result;
    logic [ROB_ID_SZ-1:0] rob_id;
  } wb_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at rr_ptr
module rr_arbiter #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  // scan farthest-first so the closest requester to rr_ptr overwrites the rest
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with per-source 1-entry hold buffers
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WORD_SIZE = wb_pkg::WORD_SIZE,
  parameter int INSTR_TYPE_SZ = wb_pkg::INSTR_TYPE_SZ,
  parameter int ROB_ID_SZ = wb_pkg::ROB_ID_SZ,
  parameter int NUM_SRC = wb_pkg::NUM_SRC
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*INSTR_TYPE_SZ-1:0] src_instr_type,
  input  logic [NUM_SRC*WORD_SIZE-1:0]     src_pc,
  input  logic [NUM_SRC*WORD_SIZE-1:0]     src_result,
  input  logic [NUM_SRC*ROB_ID_SZ-1:0]     src_rob_id,
  output logic [NUM_SRC-1:0]               src_stall,
  output logic                             wb_valid,
  output logic [INSTR_TYPE_SZ-1:0]         wb_instr_type,
  output logic [WORD_SIZE-1:0]             wb_pc,
  output logic [WORD_SIZE-1:0]             wb_result,
  output logic [ROB_ID_SZ-1:0]             wb_rob_id,
  output logic [1:0]                       wb_src
);
  wb_entry_t live [NUM_SRC];
  wb_entry_t cand [NUM_SRC];
  wb_entry_t hold_q [NUM_SRC];
  wb_entry_t wb_q;
  logic [NUM_SRC-1:0] hold_valid, req, grant;
  logic [1:0] rr_ptr, idx;
  logic any;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign live[i] = '{instr_type: src_instr_type[i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ],
                       pc: src_pc[i*WORD_SIZE +: WORD_SIZE],
                       result: src_result[i*WORD_SIZE +: WORD_SIZE],
                       rob_id: src_rob_id[i*ROB_ID_SZ +: ROB_ID_SZ]};
    assign cand[i] = hold_valid[i] ? hold_q[i] : live[i];
  end
  assign req = hold_valid | src_valid;
  rr_arbiter #(.N(NUM_SRC), .IW(2)) u_rr (
    .req(req),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= '0;
      wb_valid <= 1'b0;
      wb_q <= '0;
      wb_src <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < NUM_SRC; k++) hold_q[k] <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= any;
      if (any) begin
        wb_q <= cand[idx];
        wb_src <= idx;
        rr_ptr <= (int'(idx) == NUM_SRC - 1) ? 2'd0 : idx + 2'd1;
      end
      // a stalled source is never re-captured; its parked entry waits for a grant
      for (int k = 0; k < NUM_SRC; k++) begin
        if (grant[k]) hold_valid[k] <= 1'b0;
        else if (src_valid[k] && !hold_valid[k]) begin
          hold_q[k] <= live[k];
          hold_valid[k] <= 1'b1;
        end
      end
    end
  end
  assign src_stall = hold_valid;
  assign wb_instr_type = wb_q.instr_type;
  assign wb_pc = wb_q.pc;
  assign wb_result = wb_q.result;
  assign wb_rob_id = wb_q.rob_id;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven and sequence checks for wb_arbiter
module tb_wb_arbiter;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [2:0] src_valid;
  logic [11:0] src_instr_type;
  logic [95:0] src_pc, src_result;
  logic [20:0] src_rob_id;
  logic [2:0] src_stall;
  logic wb_valid;
  logic [3:0] wb_instr_type;
  logic [31:0] wb_pc, wb_result;
  logic [6:0] wb_rob_id;
  logic [1:0] wb_src;
  int n_chk = 0, n_fail = 0;

  wb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_instr_type(src_instr_type), .src_pc(src_pc),
    .src_result(src_result), .src_rob_id(src_rob_id), .src_stall(src_stall),
    .wb_valid(wb_valid), .wb_instr_type(wb_instr_type), .wb_pc(wb_pc),
    .wb_result(wb_result), .wb_rob_id(wb_rob_id), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic [6:0] r0, r1, r2;
    logic ev;
    logic [6:0] erob;
    logic [1:0] esrc;
    logic [2:0] estall;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] f_res(int s, logic [6:0] rob);
    return {rob, 1'b0, 8'(s), 16'hBEEF};
  endfunction
  function automatic logic [31:0] f_pc(logic [6:0] rob);
    return 32'h1000 + {23'd0, rob, 2'b00};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(logic [2:0] v, logic [6:0] r0, logic [6:0] r1, logic [6:0] r2);
    logic [6:0] r [3];
    r[0] = r0; r[1] = r1; r[2] = r2;
    src_valid = v;
    for (int i = 0; i < 3; i++) begin
      src_instr_type[i*4 +: 4] = 4'(i + 1);
      src_pc[i*32 +: 32] = f_pc(r[i]);
      src_result[i*32 +: 32] = f_res(i, r[i]);
      src_rob_id[i*7 +: 7] = r[i];
    end
  endtask

  task automatic step_chk(string t, logic ev, logic [6:0] erob, logic [1:0] esrc, logic [2:0] estall);
    @(posedge clk);
    #1;
    chk({t, " wb_valid"}, 32'(wb_valid), 32'(ev));
    chk({t, " src_stall"}, 32'(src_stall), 32'(estall));
    if (ev) begin
      chk({t, " wb_rob_id"}, 32'(wb_rob_id), 32'(erob));
      chk({t, " wb_src"}, 32'(wb_src), 32'(esrc));
      chk({t, " wb_result"}, wb_result, f_res(int'(esrc), erob));
      chk({t, " wb_pc"}, wb_pc, f_pc(erob));
      chk({t, " wb_instr_type"}, 32'(wb_instr_type), 32'(esrc) + 32'd1);
    end
  endtask

  task automatic chk_zero(string t);
    chk({t, " wb_valid"}, 32'(wb_valid), 0);
    chk({t, " src_stall"}, 32'(src_stall), 0);
    chk({t, " wb_rob_id"}, 32'(wb_rob_id), 0);
    chk({t, " wb_src"}, 32'(wb_src), 0);
    chk({t, " wb_result"}, wb_result, 0);
    chk({t, " wb_pc"}, wb_pc, 0);
    chk({t, " wb_instr_type"}, 32'(wb_instr_type), 0);
  endtask

  initial begin
    tbl[0]  = '{3'b001, 7'd5,  7'd0,  7'd0,  1'b1, 7'd5,  2'd0, 3'b000};
    tbl[1]  = '{3'b000, 7'd0,  7'd0,  7'd0,  1'b0, 7'd5,  2'd0, 3'b000};
    tbl[2]  = '{3'b100, 7'd0,  7'd0,  7'd7,  1'b1, 7'd7,  2'd2, 3'b000};
    tbl[3]  = '{3'b111, 7'd10, 7'd11, 7'd12, 1'b1, 7'd10, 2'd0, 3'b110};
    tbl[4]  = '{3'b111, 7'd20, 7'd99, 7'd98, 1'b1, 7'd11, 2'd1, 3'b101};
    tbl[5]  = '{3'b100, 7'd0,  7'd0,  7'd96, 1'b1, 7'd12, 2'd2, 3'b001};
    tbl[6]  = '{3'b000, 7'd0,  7'd0,  7'd0,  1'b1, 7'd20, 2'd0, 3'b000};
    tbl[7]  = '{3'b101, 7'd30, 7'd0,  7'd31, 1'b1, 7'd31, 2'd2, 3'b001};
    tbl[8]  = '{3'b101, 7'd30, 7'd0,  7'd32, 1'b1, 7'd30, 2'd0, 3'b100};
    tbl[9]  = '{3'b101, 7'd33, 7'd0,  7'd32, 1'b1, 7'd32, 2'd2, 3'b001};
    tbl[10] = '{3'b100, 7'd77, 7'd0,  7'd34, 1'b1, 7'd33, 2'd0, 3'b100};
    tbl[11] = '{3'b000, 7'd0,  7'd0,  7'd0,  1'b1, 7'd34, 2'd2, 3'b000};
    drive(3'b000, 7'd0, 7'd0, 7'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      drive(tbl[n].v, tbl[n].r0, tbl[n].r1, tbl[n].r2);
      step_chk($sformatf("vec%0d", n), tbl[n].ev, tbl[n].erob, tbl[n].esrc, tbl[n].estall);
    end
    drive(3'b111, 7'd40, 7'd41, 7'd42);
    step_chk("flush_pre", 1'b1, 7'd40, 2'd0, 3'b110);
    flush = 1'b1;
    drive(3'b001, 7'd50, 7'd0, 7'd0);
    step_chk("flush", 1'b0, 7'd0, 2'd0, 3'b000);
    flush = 1'b0;
    drive(3'b101, 7'd51, 7'd0, 7'd52);
    step_chk("flush_ptr", 1'b1, 7'd52, 2'd2, 3'b001);
    drive(3'b000, 7'd0, 7'd0, 7'd0);
    step_chk("flush_drain", 1'b1, 7'd51, 2'd0, 3'b000);
    drive(3'b111, 7'd60, 7'd61, 7'd62);
    step_chk("rst_pre", 1'b1, 7'd61, 2'd1, 3'b101);
    reset = 1'b1;
    flush = 1'b1;
    drive(3'b111, 7'd70, 7'd71, 7'd72);
    @(posedge clk);
    #1;
    chk_zero("rst_mid");
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    reset = 1'b0;
    drive(3'b000, 7'd0, 7'd0, 7'd0);
    step_chk("rst_idle", 1'b0, 7'd0, 2'd0, 3'b000);
    drive(3'b110, 7'd0, 7'd80, 7'd81);
    step_chk("rst_ptr", 1'b1, 7'd80, 2'd1, 3'b100);
    drive(3'b000, 7'd0, 7'd0, 7'd0);
    step_chk("rst_drain", 1'b1, 7'd81, 2'd2, 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
